// File: rtl/mv_sched.sv
// Sequential matrix-vector scheduler: y = ReLU_sat(W*x + b), one weight/input
// pair per cycle, one output row written per N+2 cycles.
module mv_sched #(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [2*$clog2(N)-1:0]    w_addr,
  input  logic [W-1:0]              w_data,
  output logic [$clog2(N)-1:0]      x_addr,
  input  logic [W-1:0]              x_data,
  output logic [$clog2(N)-1:0]      b_addr,
  input  logic [W-1:0]              b_data,
  output logic                      y_we,
  output logic [$clog2(N)-1:0]      y_addr,
  output logic [W-1:0]              y_data
);

  localparam int CW = $clog2(N);
  localparam int AW = 2*W + CW + 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WB, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            vld_q, vld_d;

  logic [2*W-1:0]  w_ext, x_ext, prod;
  logic [AW-1:0]   prod_ext;
  logic [AW:0]     sum;
  logic [W-1:0]    relu;

  // Operands are sign-extended to 2W so the low 2W bits hold the exact signed product.
  always_comb begin
    w_ext    = {{W{w_data[W-1]}}, w_data};
    x_ext    = {{W{x_data[W-1]}}, x_data};
    prod     = w_ext * x_ext;
    prod_ext = {{(AW-2*W){prod[2*W-1]}}, prod};
    sum      = {acc_q[AW-1], acc_q} + {{(AW+1-W){b_data[W-1]}}, b_data};
    if (sum[AW] || (sum == '0))
      relu = '0;
    else if (|sum[AW-1:W-1])
      relu = {1'b0, {(W-1){1'b1}}};
    else
      relu = sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = vld_q ? (acc_q + prod_ext) : acc_q;
    vld_d   = (state_q == RUN);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        col_d = col_q + 1'b1;
        if (col_q == '1)
          state_d = DRAIN;
      end
      DRAIN: state_d = WB;
      WB: begin
        if (row_q == '1) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          row_d   = row_q + 1'b1;
          col_d   = '0;
          acc_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // N is a power of two, so {row,col} is row*N+col.
  always_comb begin
    busy   = (state_q == RUN) || (state_q == DRAIN) || (state_q == WB);
    done   = (state_q == DONE);
    w_addr = (state_q == RUN) ? {row_q, col_q} : '0;
    x_addr = (state_q == RUN) ? col_q : '0;
    b_addr = row_q;
    y_addr = row_q;
    y_we   = (state_q == WB);
    y_data = (state_q == WB) ? relu : '0;
  end

endmodule

// File: tb/tb_mv_sched.sv
// Scoreboard bench for mv_sched: a driver pushes expected writes and done
// timing from an arithmetic reference model; a monitor pops and compares.
module tb_mv_sched;

  localparam int N    = 16;
  localparam int W    = 16;
  localparam int CW   = $clog2(N);
  localparam int ROWC = N + 2;
  localparam int PASS = N * (N + 2);
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, y_we;
  logic [2*CW-1:0]   w_addr;
  logic [CW-1:0]     x_addr, b_addr, y_addr;
  logic [W-1:0]      w_data = '0, x_data = '0, b_data = '0, y_data;

  logic signed [W-1:0] wmem [N*N];
  logic signed [W-1:0] xmem [N];
  logic signed [W-1:0] bmem [N];

  typedef struct { int addr; longint data; } wr_t;
  wr_t exp_q[$];
  int  done_q[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int idle_viol = 0;

  mv_sched #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_addr(w_addr), .w_data(w_data), .x_addr(x_addr), .x_data(x_data),
    .b_addr(b_addr), .b_data(b_data), .y_we(y_we), .y_addr(y_addr), .y_data(y_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    w_data <= wmem[w_addr];
    x_data <= xmem[x_addr];
    b_data <= bmem[b_addr];
  end

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: consumes expected events whenever the DUT presents a write or done.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (!busy && (w_addr != '0 || x_addr != '0)) idle_viol++;
    if (y_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_write: y_addr=%0d y_data=%0d, expected no write (cycle %0d)",
                 y_addr, $signed(y_data), cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("y_addr", longint'(y_addr), longint'(e.addr));
        check("y_data", longint'($signed(y_data)), e.data);
        check("b_addr", longint'(b_addr), longint'(e.addr));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done: done=1, expected 0 (cycle %0d)", cyc);
      end else begin
        int t;
        t = done_q.pop_front();
        check("done_cycle", longint'(cyc), longint'(t));
      end
    end
  end

  // Reference: y[i] = clamp(b[i] + sum_j w[i][j]*x[j], 0, MAXV).
  function automatic longint ref_y(input int i);
    longint s;
    s = longint'(bmem[i]);
    for (int j = 0; j < N; j++)
      s += longint'(wmem[i*N + j]) * longint'(xmem[j]);
    if (s <= 0) return 0;
    if (s > MAXV) return MAXV;
    return s;
  endfunction

  // t0 is the cycle in which start is sampled; pass writes row r in cycle t0+(r+1)*(N+2).
  task automatic push_pass(input int t0, input int last_cycle);
    wr_t e;
    for (int r = 0; r < N; r++) begin
      if (t0 + (r+1)*ROWC <= last_cycle) begin
        e.addr = r;
        e.data = ref_y(r);
        exp_q.push_back(e);
      end
    end
    if (t0 + 1 + PASS <= last_cycle) done_q.push_back(t0 + 1 + PASS);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d writes and %0d done pulses outstanding, expected 0",
               name, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_pass(input string name);
    int t0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    push_pass(t0, 32'h7fffffff);
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    wait_drain(name, PASS + 50);
  endtask

  initial begin
    int t0;
    for (int k = 0; k < N*N; k++) wmem[k] = '0;
    for (int k = 0; k < N; k++) begin xmem[k] = '0; bmem[k] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_y_we", longint'(y_we), 0);
    check("rst_w_addr", longint'(w_addr), 0);
    check("rst_x_addr", longint'(x_addr), 0);
    check("rst_b_addr", longint'(b_addr), 0);
    check("rst_y_addr", longint'(y_addr), 0);
    check("rst_y_data", longint'(y_data), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Identity weights, x[j]=j+1, bias 0
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wmem[i*N + j] = (i == j) ? W'(1) : '0;
    for (int j = 0; j < N; j++) begin xmem[j] = W'(j + 1); bmem[j] = '0; end
    run_pass("identity");
    check("identity_busy_cycles", longint'(busy_cnt), longint'(PASS));

    // All weights -1, x=1, bias 5
    for (int k = 0; k < N*N; k++) wmem[k] = '1;
    for (int j = 0; j < N; j++) begin xmem[j] = W'(1); bmem[j] = W'(5); end
    run_pass("negative");

    // Positive saturation
    for (int k = 0; k < N*N; k++) wmem[k] = W'(MAXV);
    for (int j = 0; j < N; j++) begin xmem[j] = W'(MAXV); bmem[j] = '0; end
    run_pass("saturate");

    // Zero weights, bias[i]=i-8
    for (int k = 0; k < N*N; k++) wmem[k] = '0;
    for (int j = 0; j < N; j++) bmem[j] = W'(j - 8);
    run_pass("bias_only");

    // Random full-range and small-range patterns
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < N*N; k++)
        wmem[k] = (p < 3) ? W'($urandom) : W'(int'($urandom_range(0, 127)) - 64);
      for (int j = 0; j < N; j++) begin
        xmem[j] = (p < 3) ? W'($urandom) : W'(int'($urandom_range(0, 127)) - 64);
        bmem[j] = (p < 3) ? W'($urandom) : W'(int'($urandom_range(0, 4000)) - 2000);
      end
      run_pass("random");
    end

    // Reset at cycle 100 of a pass
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    push_pass(t0, t0 + 100);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("irq_busy", longint'(busy), 0);
    check("irq_y_we", longint'(y_we), 0);
    check("irq_done", longint'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("irq_pending_writes", longint'(exp_q.size()), 0);
    check("irq_pending_done", longint'(done_q.size()), 0);
    exp_q.delete();
    done_q.delete();
    for (int k = 0; k < N*N; k++) wmem[k] = W'(int'($urandom_range(0, 255)) - 128);
    for (int j = 0; j < N; j++) xmem[j] = W'(int'($urandom_range(0, 255)) - 128);
    run_pass("after_reset");

    // Start held high for 700 cycles: restarts every PASS+2 cycles
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    push_pass(t0, 32'h7fffffff);
    push_pass(t0 + PASS + 2, 32'h7fffffff);
    push_pass(t0 + 2*(PASS + 2), 32'h7fffffff);
    repeat (700) @(negedge clk);
    start = 1'b0;
    wait_drain("held_start", 2*PASS);

    check("idle_addr_violations", longint'(idle_viol), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
